// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_pkg
// Description : Shared types, constants and helpers for the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Serializer states; PARITY is only entered when parity is built in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int   UART_DATA_BITS  = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;

    // Clock cycles per serial bit (integer division).
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_fifo
// Description : Single-clock byte FIFO with registered full/empty/level.
//               Pushes to a full FIFO and pops from an empty one are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_full;
    logic             r_empty;

    logic             w_push;
    logic             w_pop;
    logic [LVL_W-1:0] w_level_nxt;

    assign w_push = push && !r_full;
    assign w_pop  = pop  && !r_empty;

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (!w_push && w_pop) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally; flags are registered from the next occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= w_level_nxt;
            r_full  <= (w_level_nxt == LVL_W'(DEPTH));
            r_empty <= (w_level_nxt == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = r_full;
    assign empty = r_empty;
    assign level = r_level;

endmodule
`default_nettype wire

// File: rtl/uart_tx_serial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : uart_tx_serial
// Description : Memory-mapped UART transmitter. Bytes written on we/wdata are
//               buffered in a FIFO and shifted out LSB first as 8N1 serial.
//               Define UART_TX_PARITY_EN to add an even-parity bit (8E1).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_serial
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [31:0]                       wdata,
    input  logic                              ovf_clr,
    output logic                              tx,
    output logic                              busy,
    output logic                              fifo_full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              overflow
);

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);

    generate
        if (DIVISOR < 2) begin : g_div_check
            $error("uart_tx_serial: CLK_HZ/BAUD must be at least 2");
        end
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_serial: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    tx_state_t                       r_state;
    logic [CNT_W-1:0]                r_baud;
    logic [2:0]                      r_idx;
    logic [UART_DATA_BITS-1:0]       r_shift;
    logic                            r_tx;
    logic                            r_busy;
    logic                            r_overflow;
`ifdef UART_TX_PARITY_EN
    logic                            r_parity;
`endif

    logic [UART_DATA_BITS-1:0]       w_fifo_dout;
    logic                            w_fifo_full;
    logic                            w_fifo_empty;
    logic [LVL_W-1:0]                w_fifo_level;
    logic                            w_push;
    logic                            w_drop;
    logic                            w_pop;
    logic                            w_bit_end;
    logic                            w_busy_nxt;
    logic                            w_unused_wdata;

    // Only the low byte is transmitted.
    assign w_unused_wdata = ^wdata[31:UART_DATA_BITS];

    assign w_push    = we && !w_fifo_full;
    assign w_drop    = we &&  w_fifo_full;
    assign w_pop     = (r_state == IDLE) && !w_fifo_empty;
    assign w_bit_end = (r_baud == CNT_W'(DIVISOR - 1));

    // Busy next cycle: serializer leaves/stays out of IDLE, or FIFO holds data.
    assign w_busy_nxt = (r_state == IDLE)
                      ? (!w_fifo_empty || w_push)
                      : (!((r_state == STOP) && w_bit_end) || !w_fifo_empty || w_push);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata[UART_DATA_BITS-1:0]),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .level (w_fifo_level)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (ovf_clr) begin
                r_overflow <= 1'b0;
            end
            r_busy <= w_busy_nxt;
        end
    end

    // Serializer: tx is registered with the level of the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_fifo_empty) begin
                        r_shift <= w_fifo_dout;
                        r_baud  <= '0;
                        r_idx   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= START;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^w_fifo_dout;
`endif
                    end else begin
                        r_tx <= UART_IDLE_LEVEL;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= r_parity;
                            r_state <= PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= STOP;
`endif
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_idx   <= r_idx + 1'b1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= 1'b1;
                        r_state <= STOP;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_end) begin
                        r_baud  <= '0;
                        r_tx    <= UART_IDLE_LEVEL;
                        r_state <= IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= UART_IDLE_LEVEL;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_full  = w_fifo_full;
    assign fifo_level = w_fifo_level;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serial.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_uart_tx_serial
// Description : Scoreboard bench for uart_tx_serial at DIVISOR=16. Stimulus
//               queues expected bytes; a line monitor decodes frames from tx.
//               Honours UART_TX_PARITY_EN for the 8E1 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_serial;

    localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * DIV;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        we      = 1'b0;
    logic [31:0] wdata   = '0;
    logic        ovf_clr = 1'b0;
    logic        tx;
    logic        busy;
    logic        fifo_full;
    logic [4:0]  fifo_level;
    logic        overflow;

    int   cyc         = 0;
    int   n_checks    = 0;
    int   n_errors    = 0;
    int   frames_done = 0;
    int   last_wr     = 0;
    logic last_parity = 1'b0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx_serial #(
        .CLK_HZ     (1600),
        .BAUD       (100),
        .FIFO_DEPTH (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wdata      (wdata),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_level (fifo_level),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One write strobe; when accepted, the low byte is queued for the monitor.
    task automatic write_word(input logic [31:0] w, input bit acc, input bit clr);
        @(negedge clk);
        we      = 1'b1;
        wdata   = w;
        ovf_clr = clr;
        if (acc) exp_q.push_back(w[7:0]);
        @(posedge clk);
        #1;
        we      = 1'b0;
        ovf_clr = 1'b0;
        last_wr = cyc;
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames_done >= target) break;
            @(negedge clk);
        end
        chk("frames_done", frames_done, target);
    endtask

    task automatic busy_fall(output int fall);
        fall = -1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                fall = cyc;
                break;
            end
        end
    endtask

    // Line monitor: decode each frame at bit centres and score it.
    initial begin : monitor
        logic [10:0] bits;
        logic [7:0]  exp_b;
        int          st;
        bit          abort;
        forever begin
            @(negedge clk);
            if (!rst && tx === 1'b0) begin
                st    = cyc;
                abort = 1'b0;
                bits  = '0;
                for (int s = 1; s <= 8 + DIV * (FRAME_BITS - 1); s++) begin
                    if (s % DIV == 8) bits[(s - 8) / DIV] = tx;
                    @(negedge clk);
                    if (rst) begin
                        abort = 1'b1;
                        break;
                    end
                end
                if (!abort) begin
                    bits[FRAME_BITS - 1] = tx;
                    chk("start_bit", {31'd0, bits[0]}, 32'd0);
                    chk("stop_bit", {31'd0, bits[FRAME_BITS - 1]}, 32'd1);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame: got 0x%0h expected none", bits[8:1]);
                    end else begin
                        exp_b = exp_q.pop_front();
                        chk("rx_byte", {24'd0, bits[8:1]}, {24'd0, exp_b});
`ifdef UART_TX_PARITY_EN
                        last_parity = bits[9];
                        chk("parity_bit", {31'd0, bits[9]}, {31'd0, ^exp_b});
`endif
                    end
                    start_q.push_back(st);
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        int f0;
        int fall;
        bit ok;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_full", {31'd0, fifo_full}, 32'd0);
        chk("reset_level", {27'd0, fifo_level}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Test 1: single byte 0x55, latency and busy release
        write_word(32'h55, 1'b1, 1'b0);
        n = last_wr;
        chk("t1_level_after_write", {27'd0, fifo_level}, 32'd1);
        chk("t1_busy_after_write", {31'd0, busy}, 32'd1);
        busy_fall(fall);
        chk("t1_busy_fall_cycle", fall, n + 1 + FRAME_CYC);
        wait_frames(1, 50);
        chk("t1_start_latency", start_q[0], n + 1);
        chk("t1_level_end", {27'd0, fifo_level}, 32'd0);

        // Tests 4 and 2: upper bits ignored, then back-to-back pair
        f0 = frames_done;
        write_word(32'hDEADBE41, 1'b1, 1'b0);
        write_word(32'h41, 1'b1, 1'b0);
        write_word(32'h42, 1'b1, 1'b0);
        chk("t2_level_peak", {27'd0, fifo_level}, 32'd2);
        wait_frames(f0 + 3, 700);
        chk("t2_gap_a", start_q[f0 + 1] - start_q[f0], FRAME_CYC + 1);
        chk("t2_gap_b", start_q[f0 + 2] - start_q[f0 + 1], FRAME_CYC + 1);
        chk("t2_no_overflow", {31'd0, overflow}, 32'd0);

        // Test 3: overflow with 18 consecutive writes, 0x11 dropped
        repeat (5) @(negedge clk);
        f0 = frames_done;
        for (int i = 0; i < 18; i++) begin
            write_word(32'(i), (i < 17), 1'b0);
        end
        chk("t3_full", {31'd0, fifo_full}, 32'd1);
        chk("t3_level", {27'd0, fifo_level}, 32'd16);
        chk("t3_overflow", {31'd0, overflow}, 32'd1);
        write_word(32'h99, 1'b0, 1'b1);
        chk("t3_set_wins", {31'd0, overflow}, 32'd1);
        @(negedge clk);
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        wait_frames(f0 + 17, 17 * (FRAME_CYC + 1) + 200);
        busy_fall(fall);
        chk("t3_drained", exp_q.size(), 0);

        // Test 5: reset during data bit 3 of 0x34 with 0x77 still queued
        repeat (5) @(negedge clk);
        f0 = frames_done;
        write_word(32'h34, 1'b0, 1'b0);
        write_word(32'h77, 1'b0, 1'b0);
        repeat (72) @(posedge clk);
        #1;
        chk("t5_pre_tx_bit3", {31'd0, tx}, 32'd0);
        chk("t5_pre_level", {27'd0, fifo_level}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_tx", {31'd0, tx}, 32'd1);
        chk("t5_rst_level", {27'd0, fifo_level}, 32'd0);
        chk("t5_rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        chk("t5_idle_after_reset", {31'd0, ok}, 32'd1);
        chk("t5_no_frames", frames_done, f0);

`ifdef UART_TX_PARITY_EN
        // Test 6: 8E1 frame for 0x07
        f0 = frames_done;
        write_word(32'h07, 1'b1, 1'b0);
        n = last_wr;
        busy_fall(fall);
        chk("t6_busy_fall_cycle", fall, n + 1 + 176);
        wait_frames(f0 + 1, 50);
        chk("t6_parity", {31'd0, last_parity}, 32'd1);
`endif

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_serial.md
Name: uart_tx_serial

Overview:
Memory-mapped UART transmitter that consumes the CPU's character-write stream: the same we/wdata strobe used by the I/O decoder for console output. It buffers bytes in a small FIFO and shifts them out as 8N1 asynchronous serial on a physical tx pin. This is the synthesizable counterpart of the simulation console. Status outputs let software poll for space before writing.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; DIVISOR = CLK_HZ/BAUD (integer division, must be >= 2, checked by elaboration assertion)
FIFO_DEPTH, 16, byte entries; power of two, >= 2

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write strobe from I/O decoder, one byte per high cycle
wdata  in  32  CPU write data; only [7:0] used
ovf_clr  in  1  clears sticky overflow flag
tx  out  1  serial line, idle high
busy  out  1  serializer not in IDLE, or FIFO non-empty
fifo_full  out  1  count == FIFO_DEPTH
fifo_level  out  $clog2(FIFO_DEPTH+1)  current byte count
overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset (async assert, sync release) forces the following:
  - tx=1, busy=0, fifo_full=0, fifo_level=0, overflow=0.
  - FSM returns to IDLE; FIFO pointers and the baud counter go to 0.
  - Reset during a frame truncates it immediately; tx returns high, and no partial byte is resumed.
- All outputs are registered.
- Write path:
  - When we=1 and fifo_full=0, wdata[7:0] is pushed at the edge; fifo_level increments visibly after that edge.
  - When we=1 and fifo_full=1, the byte is dropped and overflow sets, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leaves the level unchanged.
  - ovf_clr=1 clears overflow. If a drop occurs in the same cycle, set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop head into the shift register, clear the baud counter and bit index, go to START. Otherwise hold tx=1.
  - START: tx=0 for DIVISOR cycles, then DATA.
  - DATA: tx=shift[0], LSB first. Each bit lasts DIVISOR cycles; after each bit, shift right and increment the 3-bit index. After bit 7, go to STOP.
  - STOP: tx=1 for DIVISOR cycles, then IDLE.
- Frame length is exactly 10*DIVISOR cycles.
- Latency: a write at edge N into an empty, idle block is popped at edge N+1, and tx falls after edge N+1 (tx low from cycle N+2).
- Back-to-back bytes:
  - IDLE lasts exactly one cycle between frames when the FIFO is non-empty.
  - Inter-frame gap is therefore 1 extra high cycle after the stop bit.
- Baud counter runs 0..DIVISOR-1 and wraps to 0 on the bit boundary.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.

Optional Feature:
UART_TX_PARITY_EN
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for DIVISOR cycles.
  - Frame becomes 11*DIVISOR cycles (8E1).
- Undefined: no PARITY state, no parity logic; 8N1 as above.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t (IDLE, START, DATA, PARITY, STOP; PARITY always declared, unused without the macro).
  - constants UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1.
  - function calc_divisor(clk_hz, baud).
- Sub-module uart_tx_fifo:
  - Synchronous single-clock FIFO (push, pop, din, dout, full, empty, level), parameterised by depth.
  - Same clk/rst convention.
- Top level contains the write-accept logic, overflow flag, baud counter and FSM.

Test Plan:
All tests use CLK_HZ=1600, BAUD=100 (DIVISOR=16).
1. Single byte: write 0x55 at edge N.
   - tx low for cycles N+2..N+17.
   - Bits then follow as 1,0,1,0,1,0,1,0, 16 cycles each, then stop high.
   - busy falls after the stop bit completes; fifo_level returns to 0.
2. Back-to-back: write 0x41, 0x42 on consecutive cycles.
   - fifo_level peaks at 2.
   - Second start bit begins exactly 161 cycles after the first.
   - Decoded bytes are 0x41 then 0x42.
3. Overflow: hold tx busy and write 18 bytes 0x00..0x11 in consecutive cycles.
   - fifo_full asserts; overflow=1.
   - The line carries exactly 17 bytes (one popped immediately plus 16 buffered), 0x00..0x10; 0x11 is dropped.
   - ovf_clr then clears overflow.
4. Upper bits ignored: write 0xDEADBE41. Line byte is 0x41.
5. Reset mid-frame: assert rst during data bit 3.
   - tx=1 and fifo_level=0 on the same cycle (async).
   - After release with no writes, tx stays high for 200 cycles.
6. With UART_TX_PARITY_EN: write 0x07.
   - Parity bit = 1.
   - Frame is 176 cycles; stop bit starts at cycle offset 160 from the start bit.
